kfpga_config_loader: RTL
========================

Name: kfpga_config_loader

Overview:
- Upstream neighbour of the fabric core; sits between the system configuration port and the core's serial configuration chain.
- Accepts the bitstream as parallel words over a valid/ready handshake.
- Clears the chain, then shifts exactly CONFIG_LENGTH bits into the core's config_in, one bit per cycle, gated by config_enable.
- Reports done or error to the host.

Parameters:
- WORD_WIDTH, 32, width of incoming bitstream words.
- CONFIG_LENGTH, 4096, total number of configuration bits in the core chain.
- CLEAR_CYCLES, 4, number of cycles cfg_nreset is held low before loading.

Ports:
- clock  input  1  fabric/config clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
- word_data  input  WORD_WIDTH  bitstream word.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts word this cycle.
- cfg_data  output  1  serial bit to core config_in.
- cfg_enable  output  1  to core config_enable; the core shifts when high.
- cfg_nreset  output  1  to core config_nreset; active-low chain clear.
- busy  output  1  high outside IDLE/DONE/ERROR.
- done  output  1  sticky; the load completed successfully.
- error  output  1  sticky; the load failed (CRC build only).

Behaviour:
- Reset (async, active-high):
  - state=IDLE; word_ready=0, cfg_data=0, cfg_enable=0, cfg_nreset=1, busy=0, done=0, error=0.
  - Bit counter, shift register and occupancy flag are cleared.
- All outputs except word_ready are registered. word_ready is combinational from state/occupancy only, never from word_valid.
- IDLE: on start=1:
  - go to CLEAR; done=0, error=0, busy=1.
- CLEAR:
  - cfg_nreset=0 for exactly CLEAR_CYCLES cycles, then cfg_nreset=1 and go to LOAD.
  - cfg_enable=0 throughout.
- LOAD:
  - word_ready=1 when the shift register is empty, or when it holds exactly one remaining valid bit (zero-bubble streaming).
  - A word is accepted on word_valid & word_ready and loaded into the shift register.
  - Bits go out LSB first: one bit per cycle, cfg_data=bit and cfg_enable=1 in the same registered cycle.
  - If no bit is available (starvation), cfg_enable=0 and cfg_data holds its last value.
  - Bit counter increments per emitted bit, range 0..CONFIG_LENGTH.
  - Final word: only the (CONFIG_LENGTH mod WORD_WIDTH) low bits are shifted (all bits if the remainder is 0). Upper bits are discarded; word_ready=0 once the final word is accepted.
  - Words accepted = ceil(CONFIG_LENGTH/WORD_WIDTH).
  - After the cycle carrying bit CONFIG_LENGTH-1 with cfg_enable=1, go to DONE (or CHECK in the CRC build).
- DONE: done=1, busy=0, cfg_enable=0. On start, re-enter CLEAR (done cleared).
- ERROR: error=1, busy=0. Left only by start (→CLEAR) or reset.
- start is ignored in CLEAR/LOAD/CHECK.
- word_valid outside LOAD: not accepted (word_ready=0). Extra words after completion are never accepted.
- Reset mid-load: immediate abort to IDLE, all outputs to reset values. The core chain content is undefined until the next load's CLEAR.

Optional Feature:
- Macro: KFPGA_CONFIG_LOADER_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is computed over every emitted configuration bit in shift order.
  - After the last bit, state CHECK accepts one extra word with word_ready=1 and cfg_enable=0. Its bits [15:0] are the expected CRC; upper bits are ignored.
  - Match → DONE. Mismatch → ERROR.
- Undefined: no CRC logic and no CHECK state; error stays 0 permanently.

Test Plan:
- Basic load (CONFIG_LENGTH=64, WORD_WIDTH=32): start, words 0x0000_0001 and 0x8000_0000 valid back-to-back → cfg_nreset low 4 cycles; 64 consecutive cfg_enable cycles; cfg_data=1 on bits 0 and 63 only; done=1 the cycle after bit 63.
- Partial final word (CONFIG_LENGTH=40): words 0xFFFF_FFFF and 0xFFFF_FFA5 → exactly 40 enable cycles; last 8 bits =1,0,1,0,0,1,0,1; a third offered word is never accepted.
- Starvation: word_valid dropped 5 cycles between words → cfg_enable low exactly 5 cycles; bit count still 64; done=1.
- Reset mid-load: assert reset after 20 bits → all outputs at reset values same cycle. A new start gives a full 4-cycle clear and a complete load.
- start during LOAD pulsed → ignored; enable count unchanged; done after 64 bits.
- CRC build: correct CRC word → done=1, error=0. CRC word with bit 0 flipped → error=1, done=0. A following start clears error and reloads.

Source files
------------

// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: clears the fabric config chain, then streams CONFIG_LENGTH bitstream bits into it LSB first.
// Define KFPGA_CONFIG_LOADER_CRC_EN to add a CRC-16-CCITT check word after the last bit (CHECK/ERROR path).
module kfpga_config_loader #(
    parameter int WORD_WIDTH    = 32,
    parameter int CONFIG_LENGTH = 4096,
    parameter int CLEAR_CYCLES  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  cfg_data,
    output logic                  cfg_enable,
    output logic                  cfg_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CW = $clog2(CONFIG_LENGTH + 1);
    localparam int SW = $clog2(WORD_WIDTH + 1);
    localparam int KW = CLEAR_CYCLES > 1 ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, LOAD, DONE, ERROR
`ifdef KFPGA_CONFIG_LOADER_CRC_EN
        , CHECK
`endif
    } state_t;

    state_t            state, state_n;
    logic [KW-1:0]     clr_cnt;
    logic [CW-1:0]     bit_cnt, loaded;
    logic [WORD_WIDTH-1:0] shreg;
    logic [SW-1:0]     sh_cnt, take;
    logic [31:0]       rem;
    logic              emit, accept;

    // Final word is truncated to the bits still owed to the chain.
    assign rem    = 32'(CONFIG_LENGTH) - 32'(loaded);
    assign take   = rem > 32'(WORD_WIDTH) ? SW'(WORD_WIDTH) : SW'(rem);
    assign emit   = state == LOAD && sh_cnt != '0;
    assign accept = word_valid && word_ready;

`ifdef KFPGA_CONFIG_LOADER_CRC_EN
    logic [15:0] crc, crc_n;
    logic        crc_fb;
    assign crc_fb     = crc[15] ^ shreg[0];
    assign crc_n      = {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    assign word_ready = (state == LOAD && sh_cnt <= SW'(1) && loaded != CW'(CONFIG_LENGTH)) || state == CHECK;
`else
    assign word_ready = state == LOAD && sh_cnt <= SW'(1) && loaded != CW'(CONFIG_LENGTH);
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERROR: state_n = start ? CLEAR : state;
            CLEAR:             state_n = clr_cnt == KW'(CLEAR_CYCLES - 1) ? LOAD : CLEAR;
`ifdef KFPGA_CONFIG_LOADER_CRC_EN
            LOAD:              state_n = bit_cnt == CW'(CONFIG_LENGTH) ? CHECK : LOAD;
            CHECK:             state_n = word_valid ? (word_data[15:0] == crc ? DONE : ERROR) : CHECK;
`else
            LOAD:              state_n = bit_cnt == CW'(CONFIG_LENGTH) ? DONE : LOAD;
`endif
            default:           state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            bit_cnt    <= '0;
            loaded     <= '0;
            shreg      <= '0;
            sh_cnt     <= '0;
            cfg_data   <= 1'b0;
            cfg_enable <= 1'b0;
            cfg_nreset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            cfg_nreset <= state_n != CLEAR;
            busy       <= !(state_n inside {IDLE, DONE, ERROR});
            done       <= state_n == DONE;
            error      <= state_n == ERROR;
            cfg_enable <= emit;
            clr_cnt    <= state == CLEAR ? clr_cnt + 1'b1 : '0;
            if (emit) begin
                cfg_data <= shreg[0];
                bit_cnt  <= bit_cnt + 1'b1;
            end
            // A word taken while one bit remains replaces it in the same cycle that bit goes out.
            if (state == CLEAR) begin
                bit_cnt <= '0;
                loaded  <= '0;
                sh_cnt  <= '0;
            end else if (accept && state == LOAD) begin
                shreg  <= word_data;
                sh_cnt <= take;
                loaded <= loaded + CW'(take);
            end else if (emit) begin
                shreg  <= shreg >> 1;
                sh_cnt <= sh_cnt - 1'b1;
            end
        end
    end

`ifdef KFPGA_CONFIG_LOADER_CRC_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            crc <= 16'hFFFF;
        else if (state == CLEAR)
            crc <= 16'hFFFF;
        else if (emit)
            crc <= crc_n;
    end
`endif
endmodule
